shift_sequencer: RTL

Multi-step controller for the 4-bit shifter unit (hold / shift-left with `il` fill / shift-right with `ir` fill / clear). The controller loads a 4-bit operand, drives the shifter's `h`, `f`, `il` and `ir` inputs for a programmed number of single-bit steps, and registers each result back into its working register. A start/busy/done handshake hands it to the ALU control path.

---
 rtl/shift_sequencer_if.sv | 29 ++
 rtl/shift_sequencer.sv | 133 +++++++++++++
 2 files changed

// File: rtl/shift_sequencer_if.sv
// Handshake and shifter-drive bundle for shift_sequencer.
interface shift_sequencer_if #(
  parameter int unsigned CNT_W = 3
);
  logic             start;
  logic [1:0]       op;
  logic [CNT_W-1:0] count;
  logic [3:0]       data_in;
  logic             sin;
  logic             rotate;
  logic [1:0]       h;
  logic [3:0]       f;
  logic             il;
  logic             ir;
  logic [3:0]       q;
  logic             sout;
  logic             busy;
  logic             done;

  modport master (
    output start, op, count, data_in, sin, rotate,
    input  h, f, il, ir, q, sout, busy, done
  );

  modport slave (
    input  start, op, count, data_in, sin, rotate,
    output h, f, il, ir, q, sout, busy, done
  );
endinterface

// File: rtl/shift_sequencer.sv
// Multi-step controller for the 4-bit hold/left/right/clear shifter.
// Define SHIFT_SEQ_ROTATE_EN to enable rotate-left/right fill from q.
module shift_sequencer #(
  parameter int unsigned CNT_W = 3
) (
  input  logic                clk,
  input  logic                rst,
  shift_sequencer_if.slave    ss
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e           state_q;
  logic [3:0]       q_q;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       op_q;
  logic [1:0]       h_q;
  logic             sout_q;
  logic             busy_q;
  logic             done_q;
  logic             il_c;
  logic             ir_c;
  logic [3:0]       s_c;
  logic [CNT_W-1:0] eff_cnt_c;

`ifdef SHIFT_SEQ_ROTATE_EN
  logic             rot_q;
`else
  logic             unused_rotate;
  assign unused_rotate = ss.rotate;
`endif

  // Clear always takes exactly one step regardless of the programmed count.
  assign eff_cnt_c = (ss.op == 2'b11) ? CNT_W'(1) : ss.count;

  // Fill bits are live only while stepping.
  always_comb begin
    il_c = 1'b0;
    ir_c = 1'b0;
    if (state_q == SHIFT) begin
      if (op_q == 2'b01) il_c = ss.sin;
      if (op_q == 2'b10) ir_c = ss.sin;
`ifdef SHIFT_SEQ_ROTATE_EN
      if (rot_q && op_q == 2'b01) il_c = q_q[3];
      if (rot_q && op_q == 2'b10) ir_c = q_q[0];
`endif
    end
  end

  // Shifter model fed by f = q.
  always_comb begin
    s_c = q_q;
    case (h_q)
      2'b01:   s_c = {q_q[2:0], il_c};
      2'b10:   s_c = {ir_c, q_q[3:1]};
      2'b11:   s_c = 4'b0000;
      default: s_c = q_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      q_q     <= 4'b0000;
      cnt_q   <= '0;
      op_q    <= 2'b00;
      h_q     <= 2'b00;
      sout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SHIFT_SEQ_ROTATE_EN
      rot_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (ss.start) begin
            q_q    <= ss.data_in;
            op_q   <= ss.op;
            cnt_q  <= eff_cnt_c;
            busy_q <= 1'b1;
`ifdef SHIFT_SEQ_ROTATE_EN
            rot_q  <= ss.rotate;
`endif
            if (eff_cnt_c != '0) begin
              state_q <= SHIFT;
              h_q     <= ss.op;
            end else begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end
        end
        SHIFT: begin
          q_q   <= s_c;
          cnt_q <= cnt_q - CNT_W'(1);
          if (op_q == 2'b01) sout_q <= q_q[3];
          if (op_q == 2'b10) sout_q <= q_q[0];
          if (cnt_q == CNT_W'(1)) begin
            state_q <= DONE;
            h_q     <= 2'b00;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          h_q     <= 2'b00;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ss.h    = h_q;
  assign ss.f    = q_q;
  assign ss.il   = il_c;
  assign ss.ir   = ir_c;
  assign ss.q    = q_q;
  assign ss.sout = sout_q;
  assign ss.busy = busy_q;
  assign ss.done = done_q;

endmodule
